// File: rtl/lmfe_pkg.sv
// Parameters and shared types for the median filter engine: window geometry,
// the empty-slot fill value, and the per-slot update select.
package lmfe_pkg;
  localparam int LMFE_N  = 49;
  localparam int LMFE_DW = 8;
  localparam int LMFE_MI = LMFE_N / 2;
  localparam logic [LMFE_DW-1:0] LMFE_FILL = '1;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INS  = 2'd1,
    SEL_LO   = 2'd2,
    SEL_HI   = 2'd3
  } sel_e;
endpackage

// File: rtl/median_sorter_cell.sv
// One slot of the sorted array: holds, loads INS, or takes a neighbour's value.
module median_sorter_cell
  import lmfe_pkg::*;
#(
  parameter int DW = LMFE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] own_i,
  input  logic [DW-1:0] lo_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] ins_i,
  input  sel_e          sel_i,
  output logic [DW-1:0] val_o
);
  logic [DW-1:0] val_q, val_d;

  always_comb begin
    val_d = own_i;
    case (sel_i)
      SEL_INS: val_d = ins_i;
      SEL_LO:  val_d = lo_i;
      SEL_HI:  val_d = hi_i;
      default: val_d = own_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '1;
    else     val_q <= val_d;
  end

  assign val_o = val_q;
endmodule

// File: rtl/median_sorter.sv
// Running median over a sorted register array: fill inserts until full, then
// each update removes DEL and inserts INS in one cycle.
module median_sorter
  import lmfe_pkg::*;
#(
  parameter int N  = LMFE_N,
  parameter int DW = LMFE_DW,
  parameter int MI = LMFE_MI
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          SE,
  input  logic [DW-1:0] INS,
  input  logic [DW-1:0] DEL,
  output logic [DW-1:0] MED,
  output logic [5:0]    CNT,
  output logic          ERR
);
  logic [N-1:0][DW-1:0] arr;
  logic [N-1:0]         gt, eq;
  sel_e                 sel [N];
  int                   g_idx, d_idx;
  logic                 full, hit, upd;
  logic [5:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;

  assign upd  = !SE;
  assign full = (cnt_q == 6'(N));
  assign hit  = |eq;

  always_comb begin
    gt = '0;
    eq = '0;
    for (int i = 0; i < N; i++) begin
      gt[i] = arr[i] > INS;
      eq[i] = arr[i] == DEL;
    end
  end

  // Insert point counts empty slots as "greater" so an all-ones INS still lands at CNT.
  always_comb begin
    g_idx = N;
    d_idx = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (gt[i] || (i >= int'(cnt_q))) g_idx = i;
      if (eq[i]) d_idx = i;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sel[i] = SEL_HOLD;
      if (upd) begin
        if (!full) begin
          if (i == g_idx)     sel[i] = SEL_INS;
          else if (i > g_idx) sel[i] = SEL_LO;
        end else if (hit && (INS > DEL)) begin
          // Hole opens at d, closes just below the first entry above INS.
          if (i == g_idx - 1)                      sel[i] = SEL_INS;
          else if ((i >= d_idx) && (i < g_idx - 1)) sel[i] = SEL_HI;
        end else if (hit && (INS < DEL)) begin
          if (i == g_idx)                        sel[i] = SEL_INS;
          else if ((i > g_idx) && (i <= d_idx))  sel[i] = SEL_LO;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (upd) begin
      if (!full)    cnt_d = cnt_q + 6'd1;
      else if (!hit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic [DW-1:0] lo, hi;
    if (i == 0) begin : g_lo_edge
      assign lo = '1;
    end else begin : g_lo
      assign lo = arr[i-1];
    end
    if (i == N - 1) begin : g_hi_edge
      assign hi = '1;
    end else begin : g_hi
      assign hi = arr[i+1];
    end
    median_sorter_cell #(.DW(DW)) u_cell (
      .clk   (clk),
      .rst   (RST),
      .own_i (arr[i]),
      .lo_i  (lo),
      .hi_i  (hi),
      .ins_i (INS),
      .sel_i (sel[i]),
      .val_o (arr[i])
    );
  end

  assign MED = arr[MI];
  assign CNT = cnt_q;
  assign ERR = err_q;
endmodule
